// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and fetch state encoding for the fetch stage
package riscv_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam int          INSTR_BYTES       = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus between fetch and imem
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  imem_req_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic                  imem_ready_i;
  logic                  imem_rvalid_i;
  logic [DATA_WIDTH-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush, load, hold and NOP fill
module if_id_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  load_i,
  input  logic                  hold_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  // Flush beats load and hold; pc is left as-is when the entry is invalidated.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      instr_o <= NOP_INSTR;
      pc_o    <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      instr_o <= NOP_INSTR;
    end else if (load_i) begin
      valid_o <= 1'b1;
      instr_o <= instr_i;
      pc_o    <= pc_i;
    end else if (!hold_i) begin
      valid_o <= 1'b0;
      instr_o <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with redirect, skid buffer and IF/ID
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(DEFAULT_NOP_INSTR)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  fetch_unit_if.master          imem,
  output logic                  if_id_valid_o,
  output logic [DATA_WIDTH-1:0] if_id_instr_o,
  output logic [ADDR_WIDTH-1:0] if_id_pc_o
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_next, redirect_pc;
  logic [DATA_WIDTH-1:0] skid_q, skid_d, id_instr;
  logic                  load_ok, id_load, id_flush;

  assign pc_next     = pc_q + ADDR_WIDTH'(INSTR_BYTES);
  assign redirect_pc = {branch_target_i[ADDR_WIDTH-1:2], 2'b00};
  assign load_ok     = !stall_i || !if_id_valid_o;

  assign imem.imem_req_o  = (state_q == S_REQ);
  assign imem.imem_addr_o = pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    skid_d   = skid_q;
    id_load  = 1'b0;
    id_flush = 1'b0;
    id_instr = imem.imem_rdata_i;
    if (branch_taken_i) begin
      // A request already accepted by memory must have its response drained in S_DROP.
      pc_d     = redirect_pc;
      id_flush = 1'b1;
      skid_d   = '0;
      case (state_q)
        S_REQ:   state_d = imem.imem_ready_i  ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem.imem_rvalid_i ? S_REQ  : S_DROP;
        S_DROP:  state_d = imem.imem_rvalid_i ? S_REQ  : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  if (imem.imem_ready_i) state_d = S_WAIT;
        S_WAIT: begin
          if (imem.imem_rvalid_i) begin
            if (load_ok) begin
              id_load = 1'b1;
              pc_d    = pc_next;
              state_d = S_REQ;
            end else begin
              skid_d  = imem.imem_rdata_i;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (load_ok) begin
            id_load  = 1'b1;
            id_instr = skid_q;
            pc_d     = pc_next;
            state_d  = S_REQ;
          end
        end
        S_DROP:  if (imem.imem_rvalid_i) state_d = S_REQ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  if_id_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(id_flush),
    .load_i (id_load),
    .hold_i (stall_i),
    .instr_i(id_instr),
    .pc_i   (pc_q),
    .valid_o(if_id_valid_o),
    .instr_o(if_id_instr_o),
    .pc_o   (if_id_pc_o)
  );

  rvalid_protocol: assert property (@(posedge clk_i) disable iff (rst_i)
    imem.imem_rvalid_i |-> (state_q == S_WAIT || state_q == S_DROP));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with randomized memory and stall/redirect
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br;
  logic [31:0] br_tgt;
  logic        v, vw;
  logic [31:0] ins, pc, insw, pcw;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) busw ();

  fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_taken_i(br), .branch_target_i(br_tgt),
    .imem(bus), .if_id_valid_o(v), .if_id_instr_o(ins), .if_id_pc_o(pc)
  );

  fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)) dut_w (
    .clk_i(clk), .rst_i(rst), .stall_i(1'b0), .branch_taken_i(1'b0), .branch_target_i(32'h0),
    .imem(busw), .if_id_valid_o(vw), .if_id_instr_o(insw), .if_id_pc_o(pcw)
  );

  // Memory model: accepts on req&&ready, answers lat cycles later with addr^SALT.
  bit          rnd_ready = 1'b0;
  bit          rnd_lat   = 1'b0;
  int          lat_cfg   = 1;
  bit          pend;
  logic [31:0] pend_addr;
  int          cnt;

  initial begin
    bus.imem_ready_i  = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      bus.imem_rvalid_i = 1'b0;
      if (rst) begin
        pend = 1'b0;
        bus.imem_ready_i = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = pend_addr ^ SALT;
            pend = 1'b0;
          end
        end
        bus.imem_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.imem_req_o && bus.imem_ready_i) begin
          pend      = 1'b1;
          pend_addr = bus.imem_addr_o;
          cnt       = rnd_lat ? int'($urandom_range(1, 3)) : lat_cfg;
        end
      end
    end
  end

  bit          wacc = 1'b0;
  logic [31:0] waddr = '0;

  initial begin
    busw.imem_ready_i  = 1'b1;
    busw.imem_rvalid_i = 1'b0;
    busw.imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      busw.imem_rvalid_i = wacc && !rst;
      busw.imem_rdata_i  = waddr ^ SALT;
      wacc  = busw.imem_req_o && !rst;
      waddr = busw.imem_addr_o;
    end
  end

  // Reference: decode sees consecutive words from the reset PC or the last redirect target.
  bit          mon_en = 1'b0;
  logic [31:0] model_pc = '0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && !rst) begin
        if (br) begin
          model_pc = {br_tgt[31:2], 2'b00};
        end else if (v && !stall) begin
          delivered++;
          checks++;
          if (pc !== model_pc) begin
            errors++;
            $display("FAIL stream_pc: got %h expected %h", pc, model_pc);
          end
          checks++;
          if (ins !== (model_pc ^ SALT)) begin
            errors++;
            $display("FAIL stream_instr: got %h expected %h", ins, model_pc ^ SALT);
          end
          model_pc = model_pc + 32'd4;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; br = 1'b0; mon_en = 1'b0;
    repeat (2) @(negedge clk);
    model_pc = 32'h0;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; br = 1'b0; br_tgt = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req_o); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", v); end
    checks++; if (ins !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", ins, NOP); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc); end
    checks++; if (busw.imem_addr_o !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_pc_wrap: got %h expected fffffff8", busw.imem_addr_o); end
    model_pc = 32'h0;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0", bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_sequential();
    bit found = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && !found; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.imem_req_o) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL seq_sync: got no request expected one within 10 cycles"); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (v !== 1'b0) begin errors++; $display("FAIL seq_gap: got valid=%b expected 0 (k=%0d)", v, k); end
      @(negedge clk);
      checks++; if (v !== 1'b1 || pc !== 32'(4 * k) || ins !== (32'(4 * k) ^ SALT)) begin
        errors++; $display("FAIL seq_word: got v=%b pc=%h instr=%h expected v=1 pc=%h", v, pc, ins, 32'(4 * k));
      end
    end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    do_reset();
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (v && pc == 32'h8) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_sync: got no pc 8 expected within 40 cycles"); end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (v !== 1'b1 || pc !== 32'h8) begin errors++; $display("FAIL stall_hold: got v=%b pc=%h expected v=1 pc=8", v, pc); end
    end
    checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_skid_noreq: got req=%b expected 0", bus.imem_req_o); end
    @(negedge clk);
    stall = 1'b0;
    checks++; if (v !== 1'b1 || pc !== 32'h8) begin errors++; $display("FAIL stall_release: got v=%b pc=%h expected v=1 pc=8", v, pc); end
    @(negedge clk);
    checks++; if (v !== 1'b1 || pc !== 32'hC || ins !== (32'hC ^ SALT)) begin
      errors++; $display("FAIL stall_skid_out: got v=%b pc=%h instr=%h expected v=1 pc=c", v, pc, ins);
    end
  endtask

  task automatic test_branch_wait();
    bit found = 1'b0;
    do_reset();
    lat_cfg = 3;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req_o && bus.imem_addr_o == 32'h8) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL brw_sync: got no req at 8 expected within 60 cycles"); end
    @(negedge clk);
    br = 1'b1; br_tgt = 32'h100;
    @(negedge clk);
    br = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (v !== 1'b0) begin errors++; $display("FAIL brw_flushed: got valid=%b expected 0", v); end
      if (bus.imem_req_o) found = 1'b1;
    end
    checks++; if (!found || bus.imem_addr_o !== 32'h100) begin
      errors++; $display("FAIL brw_addr: got req=%b addr=%h expected req=1 addr=100", bus.imem_req_o, bus.imem_addr_o);
    end
    lat_cfg = 1;
  endtask

  task automatic test_branch_rvalid();
    bit found = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req_o && bus.imem_addr_o == 32'h4) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL brr_sync: got no req at 4 expected within 20 cycles"); end
    @(negedge clk);
    #1;
    checks++; if (bus.imem_rvalid_i !== 1'b1) begin errors++; $display("FAIL brr_rvalid: got %b expected 1", bus.imem_rvalid_i); end
    br = 1'b1; br_tgt = 32'h203;
    @(negedge clk);
    br = 1'b0;
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL brr_dropped: got valid=%b expected 0", v); end
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin
      errors++; $display("FAIL brr_addr: got req=%b addr=%h expected req=1 addr=200", bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_flush_stall();
    bit found = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (v) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL fls_sync: got no valid expected within 20 cycles"); end
    stall = 1'b1; br = 1'b1; br_tgt = 32'h40;
    @(negedge clk);
    br = 1'b0;
    checks++; if (v !== 1'b0 || ins !== NOP) begin errors++; $display("FAIL fls_flush: got v=%b instr=%h expected v=0 instr=%h", v, ins, NOP); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req_o) found = 1'b1;
    end
    checks++; if (!found || bus.imem_addr_o !== 32'h40) begin
      errors++; $display("FAIL fls_addr: got req=%b addr=%h expected req=1 addr=40", bus.imem_req_o, bus.imem_addr_o);
    end
    stall = 1'b0;
  endtask

  task automatic test_random();
    int start;
    do_reset();
    rnd_ready = 1'b1;
    rnd_lat   = 1'b1;
    start = delivered;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      stall  = ($urandom_range(0, 3) == 0);
      br     = ($urandom_range(0, 24) == 0);
      br_tgt = $urandom;
    end
    @(negedge clk);
    stall = 1'b0; br = 1'b0;
    rnd_ready = 1'b0;
    rnd_lat   = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (delivered - start < 20) begin
      errors++; $display("FAIL rand_progress: got %0d deliveries expected at least 20", delivered - start);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    int n = 0;
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    do_reset();
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clk);
      if (vw) begin
        checks++; if (pcw !== exp_pc[n] || insw !== (exp_pc[n] ^ SALT)) begin
          errors++; $display("FAIL wrap_seq: got pc=%h instr=%h expected pc=%h", pcw, insw, exp_pc[n]);
        end
        n++;
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL wrap_count: got %0d words expected 3", n); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_branch_rvalid();
    test_flush_stall();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
